// File: rtl/fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_prefetch_unit
// Purpose  : Multi-line instruction prefetcher with in-order line buffer,
//            credit-limited line requests and flush redirection.
// Revision : 1.0 - initial release
// ============================================================================

module fetch_prefetch_unit #(
  parameter int                XLEN       = 32,
  parameter int                LINE_WIDTH = 128,
  parameter int                DEPTH      = 2,
  parameter logic [XLEN-1:0]   RESET_PC   = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic [XLEN-1:0]       flush_pc_i,
  output logic                  cache_req_valid_o,
  input  logic                  cache_req_ready_i,
  output logic [XLEN-1:0]       cache_req_addr_o,
  input  logic                  cache_resp_valid_i,
  input  logic [LINE_WIDTH-1:0] cache_resp_line_i,
  output logic                  issue_valid_o,
  input  logic                  issue_ready_i,
  output logic [31:0]           issue_instr_o,
  output logic [XLEN-1:0]       issue_pc_o
);

  localparam int c_instr_per_line = LINE_WIDTH / 32;
  localparam int c_line_bytes     = LINE_WIDTH / 8;
  localparam int c_idx_w          = (c_instr_per_line > 1) ? $clog2(c_instr_per_line) : 1;
  localparam int c_ptr_w          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w          = $clog2(DEPTH + 1);

  localparam logic [XLEN-1:0]    c_line_mask  = ~XLEN'(c_line_bytes - 1);
  localparam logic [XLEN-1:0]    c_line_step  = XLEN'(c_line_bytes);
  localparam logic [XLEN-1:0]    c_reset_line = RESET_PC & c_line_mask;
  localparam logic [c_idx_w-1:0] c_reset_idx  = c_idx_w'((RESET_PC >> 2) & XLEN'(c_instr_per_line - 1));
  localparam logic [c_idx_w-1:0] c_last_idx   = c_idx_w'(c_instr_per_line - 1);
  localparam logic [c_ptr_w-1:0] c_last_ptr   = c_ptr_w'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_BOOT  = 1'b0,
    ST_FETCH = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [XLEN-1:0]       r_req_pc;
  logic [XLEN-1:0]       r_resp_pc;
  logic [c_cnt_w-1:0]    r_outstanding;
  logic [c_cnt_w-1:0]    r_drop_cnt;
  logic [c_cnt_w-1:0]    r_occupancy;
  logic [c_idx_w-1:0]    r_head_idx;
  logic [c_ptr_w-1:0]    r_head;
  logic [c_ptr_w-1:0]    r_tail;
  logic [LINE_WIDTH-1:0] r_buf_line [DEPTH];
  logic [XLEN-1:0]       r_buf_addr [DEPTH];

  logic                  w_credit_ok;
  logic                  w_req_valid;
  logic                  w_req_fire;
  logic                  w_buf_nonempty;
  logic                  w_issue_valid;
  logic                  w_issue_fire;
  logic                  w_pop;
  logic                  w_drop;
  logic                  w_push;
  logic [c_cnt_w-1:0]    w_out_after_resp;
  logic [XLEN-1:0]       w_flush_line;
  logic [c_idx_w-1:0]    w_flush_idx;
  logic [LINE_WIDTH-1:0] w_head_line;
  logic [31:0]           w_head_words [c_instr_per_line];

  function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_last_ptr) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BOOT:  w_state_nxt = ST_FETCH;
      ST_FETCH: w_state_nxt = ST_FETCH;
      default:  w_state_nxt = ST_FETCH;
    endcase
    if (flush_i) begin
      w_state_nxt = ST_FETCH;
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake and credit decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // Buffered plus in-flight lines may never exceed the buffer depth.
    w_credit_ok      = ({1'b0, r_outstanding} + {1'b0, r_occupancy}) < (c_cnt_w + 1)'(DEPTH);
    w_req_valid      = (r_state == ST_FETCH) && !flush_i && w_credit_ok;
    w_req_fire       = w_req_valid && cache_req_ready_i;
    w_buf_nonempty   = (r_occupancy != '0);
    w_issue_valid    = w_buf_nonempty && !flush_i;
    w_issue_fire     = w_issue_valid && issue_ready_i;
    w_pop            = w_issue_fire && (r_head_idx == c_last_idx);
    w_drop           = cache_resp_valid_i && (r_drop_cnt != '0);
    w_push           = cache_resp_valid_i && !w_drop && !flush_i;
    w_out_after_resp = r_outstanding - c_cnt_w'(cache_resp_valid_i);
    w_flush_line     = flush_pc_i & c_line_mask;
    w_flush_idx      = c_idx_w'((flush_pc_i >> 2) & XLEN'(c_instr_per_line - 1));
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_req_pc      <= c_reset_line;
      r_resp_pc     <= c_reset_line;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_occupancy   <= '0;
      r_head_idx    <= c_reset_idx;
      r_head        <= '0;
      r_tail        <= '0;
    end else if (flush_i) begin
      // Everything still in flight (net of this cycle's response) is stale.
      r_req_pc      <= w_flush_line;
      r_resp_pc     <= w_flush_line;
      r_outstanding <= w_out_after_resp;
      r_drop_cnt    <= w_out_after_resp;
      r_occupancy   <= '0;
      r_head_idx    <= w_flush_idx;
      r_head        <= '0;
      r_tail        <= '0;
    end else begin
      r_outstanding <= w_out_after_resp + c_cnt_w'(w_req_fire);
      r_occupancy   <= r_occupancy + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
      if (w_req_fire) begin
        r_req_pc <= r_req_pc + c_line_step;
      end
      if (w_drop) begin
        r_drop_cnt <= r_drop_cnt - 1'b1;
      end
      if (w_push) begin
        r_resp_pc <= r_resp_pc + c_line_step;
        r_tail    <= ptr_inc(r_tail);
      end
      if (w_pop) begin
        r_head_idx <= '0;
        r_head     <= ptr_inc(r_head);
      end else if (w_issue_fire) begin
        r_head_idx <= r_head_idx + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffer storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf_line[i] <= '0;
        r_buf_addr[i] <= '0;
      end
    end else if (w_push) begin
      r_buf_line[r_tail] <= cache_resp_line_i;
      r_buf_addr[r_tail] <= r_resp_pc;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign w_head_line = r_buf_line[r_head];

  generate
    for (genvar gi = 0; gi < c_instr_per_line; gi++) begin : g_head_words
      assign w_head_words[gi] = w_head_line[32*gi +: 32];
    end
  endgenerate

  assign cache_req_valid_o = w_req_valid;
  assign cache_req_addr_o  = r_req_pc;
  assign issue_valid_o     = w_issue_valid;
  // Data outputs read zero whenever the buffer is empty.
  assign issue_instr_o     = w_buf_nonempty ? w_head_words[r_head_idx] : 32'h0;
  assign issue_pc_o        = w_buf_nonempty ? (r_buf_addr[r_head] + XLEN'({r_head_idx, 2'b00}))
                                            : '0;

endmodule

`default_nettype wire

// File: tb/tb_fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_prefetch_unit
// Purpose  : Directed scoreboard bench for fetch_prefetch_unit.
// Revision : 1.0 - initial release
// ============================================================================

module tb_fetch_prefetch_unit;

  localparam int XLEN       = 32;
  localparam int LINE_WIDTH = 128;
  localparam int DEPTH      = 2;

  logic                  clk_i;
  logic                  rst_n_i;
  logic                  flush_i;
  logic [XLEN-1:0]       flush_pc_i;
  logic                  cache_req_valid_o;
  logic                  cache_req_ready_i;
  logic [XLEN-1:0]       cache_req_addr_o;
  logic                  cache_resp_valid_i;
  logic [LINE_WIDTH-1:0] cache_resp_line_i;
  logic                  issue_valid_o;
  logic                  issue_ready_i;
  logic [31:0]           issue_instr_o;
  logic [XLEN-1:0]       issue_pc_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_req_q [$];
  logic [63:0] exp_iss_q [$];

  fetch_prefetch_unit #(
    .XLEN       (XLEN),
    .LINE_WIDTH (LINE_WIDTH),
    .DEPTH      (DEPTH),
    .RESET_PC   (32'h100)
  ) dut (
    .clk_i              (clk_i),
    .rst_n_i            (rst_n_i),
    .flush_i            (flush_i),
    .flush_pc_i         (flush_pc_i),
    .cache_req_valid_o  (cache_req_valid_o),
    .cache_req_ready_i  (cache_req_ready_i),
    .cache_req_addr_o   (cache_req_addr_o),
    .cache_resp_valid_i (cache_resp_valid_i),
    .cache_resp_line_i  (cache_resp_line_i),
    .issue_valid_o      (issue_valid_o),
    .issue_ready_i      (issue_ready_i),
    .issue_instr_o      (issue_instr_o),
    .issue_pc_o         (issue_pc_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Instruction word stored at a given byte address in the fake memory.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [LINE_WIDTH-1:0] mem_line(input logic [31:0] a);
    return {mem_word(a + 32'd12), mem_word(a + 32'd8), mem_word(a + 32'd4), mem_word(a)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_resp(input logic [31:0] a);
    cache_resp_valid_i = 1'b1;
    cache_resp_line_i  = mem_line(a);
  endtask

  task automatic expect_line(input logic [31:0] a, input int first);
    for (int k = first; k < 4; k++) begin
      exp_iss_q.push_back({a + 32'(4 * k), mem_word(a + 32'(4 * k))});
    end
  endtask

  // Monitor: every handshake on either output port pops the scoreboard.
  always @(negedge clk_i) begin
    if (rst_n_i) begin
      if (issue_valid_o && issue_ready_i) begin
        if (exp_iss_q.size() == 0) begin
          chk("issue_unexpected_pc", {32'h0, issue_pc_o}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          logic [63:0] e;
          e = exp_iss_q.pop_front();
          chk("issue_pc", {32'h0, issue_pc_o}, {32'h0, e[63:32]});
          chk("issue_instr", {32'h0, issue_instr_o}, {32'h0, e[31:0]});
        end
      end
      if (cache_req_valid_o && cache_req_ready_i) begin
        if (exp_req_q.size() == 0) begin
          chk("req_unexpected_addr", {32'h0, cache_req_addr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          logic [31:0] ea;
          ea = exp_req_q.pop_front();
          chk("req_addr", {32'h0, cache_req_addr_o}, {32'h0, ea});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n_i            = 1'b0;
    flush_i            = 1'b0;
    flush_pc_i         = '0;
    cache_req_ready_i  = 1'b1;
    cache_resp_valid_i = 1'b0;
    cache_resp_line_i  = '0;
    issue_ready_i      = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_req_valid", {63'h0, cache_req_valid_o}, 64'h0);
    chk("rst_req_addr", {32'h0, cache_req_addr_o}, 64'h100);
    chk("rst_issue_valid", {63'h0, issue_valid_o}, 64'h0);
    chk("rst_issue_instr", {32'h0, issue_instr_o}, 64'h0);
    chk("rst_issue_pc", {32'h0, issue_pc_o}, 64'h0);

    // Boot cycle, then two back-to-back requests and a credit stall.
    step();
    rst_n_i = 1'b1;
    exp_req_q.push_back(32'h100);
    exp_req_q.push_back(32'h110);
    @(negedge clk_i);
    chk("boot_no_req", {63'h0, cache_req_valid_o}, 64'h0);
    step();
    @(negedge clk_i);
    chk("first_req_valid", {63'h0, cache_req_valid_o}, 64'h1);
    step();
    step();
    @(negedge clk_i);
    chk("credit_block_a", {63'h0, cache_req_valid_o}, 64'h0);
    step();
    @(negedge clk_i);
    chk("credit_block_b", {63'h0, cache_req_valid_o}, 64'h0);

    // Line 0x100 streams out one word per cycle; 0x120 follows the pop.
    step();
    send_resp(32'h100);
    issue_ready_i = 1'b1;
    expect_line(32'h100, 0);
    exp_req_q.push_back(32'h120);
    step();
    cache_resp_valid_i = 1'b0;
    @(negedge clk_i);
    chk("issue_latency", {63'h0, issue_valid_o}, 64'h1);
    step();
    step();
    step();
    @(negedge clk_i);
    chk("no_req_before_pop", {63'h0, cache_req_valid_o}, 64'h0);
    step();
    @(negedge clk_i);
    chk("req_after_pop", {63'h0, cache_req_valid_o}, 64'h1);
    chk("empty_no_issue", {63'h0, issue_valid_o}, 64'h0);

    // Issue back-pressure holds the head instruction.
    step();
    send_resp(32'h110);
    issue_ready_i = 1'b0;
    step();
    cache_resp_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("stall_valid", {63'h0, issue_valid_o}, 64'h1);
      chk("stall_pc", {32'h0, issue_pc_o}, 64'h110);
      chk("stall_instr", {32'h0, issue_instr_o}, {32'h0, mem_word(32'h110)});
      chk("stall_no_req", {63'h0, cache_req_valid_o}, 64'h0);
      step();
    end
    issue_ready_i = 1'b1;
    expect_line(32'h110, 0);
    exp_req_q.push_back(32'h130);
    repeat (4) step();

    // Flush with two requests in flight: both stale lines must vanish.
    step();
    flush_i    = 1'b1;
    flush_pc_i = 32'h20A;
    exp_req_q.push_back(32'h200);
    exp_req_q.push_back(32'h210);
    expect_line(32'h200, 2);
    @(negedge clk_i);
    chk("flush_no_issue", {63'h0, issue_valid_o}, 64'h0);
    chk("flush_no_req", {63'h0, cache_req_valid_o}, 64'h0);
    step();
    flush_i = 1'b0;
    @(negedge clk_i);
    chk("flush_wait_credit", {63'h0, cache_req_valid_o}, 64'h0);
    step();
    send_resp(32'h120);
    step();
    send_resp(32'h130);
    step();
    cache_resp_valid_i = 1'b0;
    @(negedge clk_i);
    chk("stale_not_buffered", {63'h0, issue_valid_o}, 64'h0);
    step();
    send_resp(32'h200);
    step();
    cache_resp_valid_i = 1'b0;
    exp_req_q.push_back(32'h220);
    step();
    step();

    // Flush coinciding with a live response while a line waits to issue.
    step();
    send_resp(32'h210);
    issue_ready_i = 1'b0;
    step();
    send_resp(32'h220);
    flush_i       = 1'b1;
    flush_pc_i    = 32'h300;
    issue_ready_i = 1'b1;
    exp_req_q.push_back(32'h300);
    exp_req_q.push_back(32'h310);
    @(negedge clk_i);
    chk("flush_resp_no_issue", {63'h0, issue_valid_o}, 64'h0);
    step();
    flush_i            = 1'b0;
    cache_resp_valid_i = 1'b0;
    @(negedge clk_i);
    chk("flush_resp_dropped", {63'h0, issue_valid_o}, 64'h0);
    step();

    // Request back-pressure: address held until the cache is ready.
    step();
    send_resp(32'h300);
    issue_ready_i     = 1'b0;
    cache_req_ready_i = 1'b0;
    step();
    send_resp(32'h310);
    step();
    cache_resp_valid_i = 1'b0;
    issue_ready_i      = 1'b1;
    expect_line(32'h300, 0);
    expect_line(32'h310, 0);
    repeat (4) step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("hold_req_valid", {63'h0, cache_req_valid_o}, 64'h1);
      chk("hold_req_addr", {32'h0, cache_req_addr_o}, 64'h320);
      step();
    end
    cache_req_ready_i = 1'b1;
    exp_req_q.push_back(32'h320);
    exp_req_q.push_back(32'h330);
    repeat (5) step();

    @(negedge clk_i);
    chk("req_queue_drained", 64'(exp_req_q.size()), 64'h0);
    chk("issue_queue_drained", 64'(exp_iss_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
